pe_feeder: RTL and testbench
============================

// Module: pe_feeder
// PURPOSE
//   Upstream sequencer for one PE. Buffers an incoming weight/activation word stream in a FIFO and
//   executes a command queue (LOADW, LOADA, START, SUMS). It drives the PE control pulses and data
//   inputs with the exact timing the PE needs: contiguous bursts, a one-cycle gap, and done-wait.
// PARAMETERS
//   dataSize    8   width of weight/activation words
//   FIFO_DEPTH  16  input FIFO depth in words (power of 2), equal to the PE spad depth
// PORTS
//   clk          in   1              clock
//   nrst         in   1              asynchronous active-low reset
//   in_data      in   dataSize       stream word (weight or activation)
//   in_valid     in   1              stream word valid
//   in_ready     out  1              FIFO can accept a word
//   cmd_valid    in   1              command valid
//   cmd_ready    out  1              command accepted this cycle if cmd_valid
//   cmd_op       in   2              0=LOADW 1=LOADA 2=START 3=SUMS
//   cmd_len      in   8              LOADW/LOADA: word count; SUMS: sums pulse cycles; START: ignored
//   pe_weights   out  dataSize       to PE weights_i
//   pe_acts      out  dataSize       to PE acts_i
//   pe_loadw     out  1              to PE ctrl_loadw
//   pe_loada     out  1              to PE ctrl_loada
//   pe_start     out  1              to PE ctrl_start
//   pe_sums      out  1              to PE ctrl_sums
//   pe_wcount    out  8              to PE ctrl_wcount; len of last LOADW
//   pe_acount    out  8              to PE ctrl_acount; len of last LOADA
//   pe_done      in   1              from PE flag_done; level, sticky
//   busy         out  1              FSM not IDLE
//   fifo_count   out  $clog2(FIFO_DEPTH)+1  words held in FIFO
// BEHAVIOUR
// - Reset (async, nrst=0): FSM=IDLE and FIFO empty. All outputs 0 except in_ready=1 and cmd_ready=1.
//   pe_wcount=pe_acount=0. The pe_done edge register is 0. Reset mid-burst aborts immediately.
// - FIFO: push when in_valid&&in_ready; in_ready = (fifo_count<FIFO_DEPTH).
//   A simultaneous push and pop leaves the count unchanged. Pointers wrap modulo FIFO_DEPTH.
//   Words left over after a burst remain queued for the next command.
// - All pe_* outputs are registered.
// - cmd_ready=1 only in IDLE. The FSM states are IDLE, FILL, BURST, GAP, SUMS and WAIT_DONE.
// - IDLE: on a command handshake at cycle T, latch op and len (len>FIFO_DEPTH saturates to FIFO_DEPTH).
//   - LOADW/LOADA with len=0: no-op, stay IDLE.
//   - LOADW/LOADA otherwise: pe_wcount (LOADW) or pe_acount (LOADA) <= len at T+1; go FILL.
//   - START: pe_start=1 for exactly 1 cycle (T+1); go WAIT_DONE.
//   - SUMS with len=0: no-op. SUMS otherwise: go SUMS.
// - FILL: wait until fifo_count>=len, then pop word0 onto pe_weights (LOADW) or pe_acts (LOADA).
//   The matching load pulse is high for exactly that one cycle. Go BURST.
// - BURST: pop one word per cycle onto the same output (words 1..len-1) with the pulse low.
//   The burst is contiguous, with no bubbles, because FILL guaranteed len words were present.
//   After the last word: go GAP. Unused data outputs hold their last value.
// - GAP: one idle cycle, so the PE returns to IDLE before any further pulse.
//   The next control pulse comes no earlier than len+1 cycles after the load pulse. Then go IDLE.
// - SUMS: pe_sums=1 for exactly len consecutive cycles, then 0; go GAP.
// - WAIT_DONE: wait for a rising edge of pe_done (prev=0, now=1), then go IDLE.
//   The edge register samples every cycle in all states.
//   If pe_done is already 1 at START, the block waits until pe_done falls and rises again
//   (a PE reset releases it).
// - Never asserts more than one of pe_loadw/pe_loada/pe_start/pe_sums in the same cycle.
// - len counters are 8-bit; no arithmetic wraps, because len<=FIFO_DEPTH.
// TESTING
// - Push 3 weights 0x11,0x22,0x33; then cmd LOADW len=3 -> pe_loadw high 1 cycle with pe_weights=0x11;
//   0x22 and 0x33 follow on the next 2 cycles; pe_wcount=3; then GAP, then cmd_ready=1.
// - cmd LOADA len=5 with the FIFO empty; push 1 word per 2 cycles -> no pe_loada until 5 words are held;
//   then 5 contiguous words on pe_acts.
// - Push 20 words with in_valid held high -> in_ready=0 at fifo_count=16; no data loss.
//   After a LOADW len=16 burst (which pops concurrently), the remaining 4 words are intact and in order.
// - cmd START -> pe_start 1 cycle, busy=1; hold pe_done=0 for 40 cycles, then raise it ->
//   IDLE the next cycle; commands are blocked meanwhile.
// - cmd SUMS len=4 -> pe_sums high exactly 4 cycles; cmd LOADW len=0 -> no pulse, cmd_ready stays 1.
// - Assert nrst low mid-BURST (word 2 of 6) -> all pe_* outputs 0, FIFO empty, IDLE; a new LOADW works.

Source files
------------

// File: rtl/pe_feeder.sv
// Upstream sequencer for one PE: input FIFO for the weight/activation stream plus a command FSM
// that drives the PE load/start/sums pulses with burst, gap and done-wait timing.
//
// state     | meaning
// IDLE      | accepting commands
// FILL      | waiting for len words in the FIFO, then emits word0 with the load pulse
// BURST     | emitting words 1..len-1, one per cycle
// GAP       | one idle cycle before returning to IDLE
// SUMS      | holding pe_sums high for len cycles
// WAIT_DONE | waiting for a rising edge of pe_done
module pe_feeder #(
    parameter int dataSize   = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          nrst,
    input  logic [dataSize-1:0]           in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [1:0]                    cmd_op,
    input  logic [7:0]                    cmd_len,
    output logic [dataSize-1:0]           pe_weights,
    output logic [dataSize-1:0]           pe_acts,
    output logic                          pe_loadw,
    output logic                          pe_loada,
    output logic                          pe_start,
    output logic                          pe_sums,
    output logic [7:0]                    pe_wcount,
    output logic [7:0]                    pe_acount,
    input  logic                          pe_done,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [7:0] DEPTH_L = 8'(FIFO_DEPTH);

    localparam logic [1:0] OP_LOADW = 2'd0;
    localparam logic [1:0] OP_LOADA = 2'd1;
    localparam logic [1:0] OP_START = 2'd2;
    localparam logic [1:0] OP_SUMS  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_FILL, S_BURST, S_GAP, S_SUMS, S_WAIT_DONE
    } state_t;

    state_t                state;
    logic [dataSize-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  push;
    logic                  pop;
    logic                  enough;
    logic [dataSize-1:0]   head;
    logic [7:0]            len_sat;
    logic [7:0]            len_q;
    logic [7:0]            rem;
    logic                  is_w;
    logic                  done_q;

    assign in_ready  = (fifo_count < CW'(FIFO_DEPTH));
    assign push      = in_valid && in_ready;
    assign enough    = (8'(fifo_count) >= len_q);
    assign pop       = ((state == S_FILL) && enough) || (state == S_BURST);
    assign head      = mem[rd_ptr];
    assign len_sat   = (cmd_len > DEPTH_L) ? DEPTH_L : cmd_len;
    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= S_IDLE;
            pe_weights <= '0;
            pe_acts    <= '0;
            pe_loadw   <= 1'b0;
            pe_loada   <= 1'b0;
            pe_start   <= 1'b0;
            pe_sums    <= 1'b0;
            pe_wcount  <= '0;
            pe_acount  <= '0;
            len_q      <= '0;
            rem        <= '0;
            is_w       <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q   <= pe_done;
            pe_loadw <= 1'b0;
            pe_loada <= 1'b0;
            pe_start <= 1'b0;
            pe_sums  <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        unique case (cmd_op)
                            OP_LOADW, OP_LOADA: begin
                                if (len_sat != 8'd0) begin
                                    is_w  <= (cmd_op == OP_LOADW);
                                    len_q <= len_sat;
                                    if (cmd_op == OP_LOADW) pe_wcount <= len_sat;
                                    else                    pe_acount <= len_sat;
                                    state <= S_FILL;
                                end
                            end
                            OP_START: begin
                                pe_start <= 1'b1;
                                state    <= S_WAIT_DONE;
                            end
                            OP_SUMS: begin
                                if (len_sat != 8'd0) begin
                                    pe_sums <= 1'b1;
                                    rem     <= len_sat - 8'd1;
                                    state   <= (len_sat == 8'd1) ? S_GAP : S_SUMS;
                                end
                            end
                            default: state <= S_IDLE;
                        endcase
                    end
                end
                S_FILL: begin
                    if (enough) begin
                        if (is_w) begin
                            pe_weights <= head;
                            pe_loadw   <= 1'b1;
                        end else begin
                            pe_acts  <= head;
                            pe_loada <= 1'b1;
                        end
                        rem   <= len_q - 8'd1;
                        state <= (len_q == 8'd1) ? S_GAP : S_BURST;
                    end
                end
                S_BURST: begin
                    if (is_w) pe_weights <= head;
                    else      pe_acts    <= head;
                    rem <= rem - 8'd1;
                    if (rem == 8'd1) state <= S_GAP;
                end
                S_GAP: state <= S_IDLE;
                S_SUMS: begin
                    pe_sums <= 1'b1;
                    rem     <= rem - 8'd1;
                    if (rem == 8'd1) state <= S_GAP;
                end
                // a level already high at START never counts; only a fresh 0->1 edge releases us
                S_WAIT_DONE: begin
                    if (pe_done && !done_q) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pe_feeder.sv
// Self-checking bench for pe_feeder: a queue models the FIFO contents, bursts are popped and compared.
module tb_pe_feeder;
    localparam logic [1:0] OP_LOADW = 2'd0;
    localparam logic [1:0] OP_LOADA = 2'd1;
    localparam logic [1:0] OP_START = 2'd2;
    localparam logic [1:0] OP_SUMS  = 2'd3;

    logic       clk = 1'b0;
    logic       nrst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_len;
    logic [7:0] pe_weights;
    logic [7:0] pe_acts;
    logic       pe_loadw;
    logic       pe_loada;
    logic       pe_start;
    logic       pe_sums;
    logic [7:0] pe_wcount;
    logic [7:0] pe_acount;
    logic       pe_done;
    logic       busy;
    logic [4:0] fifo_count;

    int checks = 0;
    int errors = 0;
    logic [7:0] fifo_model[$];

    pe_feeder #(.dataSize(8), .FIFO_DEPTH(16)) dut (
        .clk(clk), .nrst(nrst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_len(cmd_len),
        .pe_weights(pe_weights), .pe_acts(pe_acts),
        .pe_loadw(pe_loadw), .pe_loada(pe_loada), .pe_start(pe_start), .pe_sums(pe_sums),
        .pe_wcount(pe_wcount), .pe_acount(pe_acount), .pe_done(pe_done),
        .busy(busy), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic push_words(input int n, input int idle, input logic [7:0] base, input logic [7:0] step);
        int guard;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'(base + i * step);
            guard = 0;
            while (!in_ready && guard < 500) begin
                @(negedge clk);
                guard++;
            end
            if (!in_ready) begin
                checks++; errors++;
                $display("FAIL push_timeout: in_ready=%0b required 1", in_ready);
            end
            @(posedge clk);
            fifo_model.push_back(in_data);
            if (idle > 0) begin
                @(negedge clk);
                in_valid = 1'b0;
                repeat (idle - 1) @(negedge clk);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [7:0] len);
        int guard;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = len;
        guard = 0;
        while (!cmd_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (!cmd_ready) begin
            errors++;
            $display("FAIL cmd_handshake: cmd_ready=%0b required 1", cmd_ready);
        end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic check_burst(input bit is_w, input int len, input int budget);
        int prev;
        int guard;
        logic [7:0] exp;
        logic [7:0] got;
        logic pulse;
        prev  = -1;
        guard = 0;
        pulse = is_w ? pe_loadw : pe_loada;
        while (!pulse && guard < budget) begin
            prev = fifo_model.size();
            @(negedge clk);
            guard++;
            pulse = is_w ? pe_loadw : pe_loada;
            checks++;
            if (!pulse && prev >= len) begin
                errors++;
                $display("FAIL burst_stall: no load pulse with %0d words held, required pulse at %0d", prev, len);
            end
        end
        checks++;
        if (!pulse) begin
            errors++;
            $display("FAIL burst_timeout: load pulse=%0b required 1", pulse);
            return;
        end
        checks++;
        if (prev < len) begin
            errors++;
            $display("FAIL burst_early: pulse with %0d words held, required >= %0d", prev, len);
        end
        for (int i = 0; i < len; i++) begin
            if (i > 0) @(negedge clk);
            exp = 8'hxx;
            if (fifo_model.size() > 0) exp = fifo_model.pop_front();
            got   = is_w ? pe_weights : pe_acts;
            pulse = is_w ? pe_loadw : pe_loada;
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL burst_word%0d: got %02h required %02h", i, got, exp);
            end
            checks++;
            if (pulse !== (i == 0)) begin
                errors++;
                $display("FAIL burst_pulse%0d: got %0b required %0b", i, pulse, (i == 0));
            end
        end
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL gap_ready: cmd_ready=%0b required 0", cmd_ready);
        end
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_gap: cmd_ready=%0b busy=%0b required 1/0", cmd_ready, busy);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        logic [46:0] outs;
        outs = {pe_weights, pe_acts, pe_loadw, pe_loada, pe_start, pe_sums,
                pe_wcount, pe_acount, busy, fifo_count};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL %s_outputs: got %h required 0", tag, outs);
        end
        checks++;
        if (in_ready !== 1'b1 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready: in_ready=%0b cmd_ready=%0b required 1/1", tag, in_ready, cmd_ready);
        end
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        in_valid = 1'b0; in_data = '0;
        cmd_valid = 1'b0; cmd_op = '0; cmd_len = '0;
        pe_done = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        nrst = 1'b1;
    endtask

    task automatic test_loadw_basic();
        push_words(3, 0, 8'h11, 8'h11);
        send_cmd(OP_LOADW, 8'd3);
        checks++;
        if (pe_wcount !== 8'd3) begin
            errors++;
            $display("FAIL loadw_wcount: got %0d required 3", pe_wcount);
        end
        check_burst(1'b1, 3, 50);
    endtask

    task automatic test_loada_slow();
        fork
            begin
                send_cmd(OP_LOADA, 8'd5);
                check_burst(1'b0, 5, 200);
            end
            begin
                repeat (3) @(negedge clk);
                push_words(5, 1, 8'hA0, 8'h03);
            end
        join
        checks++;
        if (pe_acount !== 8'd5) begin
            errors++;
            $display("FAIL loada_acount: got %0d required 5", pe_acount);
        end
    endtask

    task automatic test_fifo_full();
        int guard;
        fork
            push_words(20, 0, 8'h40, 8'h01);
            begin
                guard = 0;
                while (fifo_count != 5'd16 && guard < 100) begin
                    @(negedge clk);
                    guard++;
                end
                checks++;
                if (fifo_count !== 5'd16 || in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL fifo_full: count=%0d in_ready=%0b required 16/0", fifo_count, in_ready);
                end
                repeat (3) @(negedge clk);
                checks++;
                if (fifo_count !== 5'd16) begin
                    errors++;
                    $display("FAIL fifo_hold: count=%0d required 16", fifo_count);
                end
                send_cmd(OP_LOADW, 8'd16);
                check_burst(1'b1, 16, 50);
            end
        join
        checks++;
        if (fifo_count !== 5'd4) begin
            errors++;
            $display("FAIL fifo_leftover: count=%0d required 4", fifo_count);
        end
        send_cmd(OP_LOADA, 8'd4);
        check_burst(1'b0, 4, 50);
        checks++;
        if (pe_wcount !== 8'd16 || pe_acount !== 8'd4) begin
            errors++;
            $display("FAIL counts_after_full: wcount=%0d acount=%0d required 16/4", pe_wcount, pe_acount);
        end
    endtask

    task automatic test_start_done();
        int leaks;
        send_cmd(OP_START, 8'd0);
        checks++;
        if (pe_start !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL start_pulse: pe_start=%0b busy=%0b required 1/1", pe_start, busy);
        end
        cmd_valid = 1'b1; cmd_op = OP_SUMS; cmd_len = 8'd2;
        leaks = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (pe_start || pe_sums || cmd_ready || !busy) leaks++;
        end
        cmd_valid = 1'b0;
        checks++;
        if (leaks != 0) begin
            errors++;
            $display("FAIL start_wait: %0d cycles not blocked, required 0", leaks);
        end
        pe_done = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL done_release: busy=%0b cmd_ready=%0b required 0/1", busy, cmd_ready);
        end
        send_cmd(OP_START, 8'd0);
        repeat (10) @(negedge clk);
        pe_done = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL sticky_done: busy=%0b required 1", busy);
        end
        pe_done = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL done_rerise: busy=%0b required 0", busy);
        end
        pe_done = 1'b0;
    endtask

    task automatic test_sums_and_noop();
        int high;
        int first;
        int last;
        send_cmd(OP_SUMS, 8'd4);
        high = 0; first = -1; last = -1;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            if (pe_sums) begin
                high++;
                if (first < 0) first = i;
                last = i;
            end
        end
        checks++;
        if (high != 4 || (last - first + 1) != 4 || first != 0) begin
            errors++;
            $display("FAIL sums_len: high=%0d span=%0d first=%0d required 4/4/0", high, last - first + 1, first);
        end
        send_cmd(OP_LOADW, 8'd0);
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || pe_loadw !== 1'b0 || pe_wcount !== 8'd16) begin
            errors++;
            $display("FAIL loadw_zero: ready=%0b busy=%0b loadw=%0b wcount=%0d required 1/0/0/16",
                     cmd_ready, busy, pe_loadw, pe_wcount);
        end
    endtask

    task automatic test_reset_mid_burst();
        int guard;
        push_words(6, 0, 8'hC0, 8'h01);
        send_cmd(OP_LOADW, 8'd6);
        guard = 0;
        while (!pe_loadw && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (pe_weights !== 8'hC0) begin
            errors++;
            $display("FAIL midburst_word0: got %02h required c0", pe_weights);
        end
        repeat (2) @(negedge clk);
        nrst = 1'b0;
        #1;
        check_reset_outputs("midburst_reset");
        fifo_model.delete();
        @(negedge clk);
        nrst = 1'b1;
        push_words(2, 0, 8'h5A, 8'h11);
        send_cmd(OP_LOADW, 8'd2);
        check_burst(1'b1, 2, 50);
    endtask

    initial begin
        test_reset();
        test_loadw_basic();
        test_loada_slow();
        test_fifo_full();
        test_start_done();
        test_sums_and_noop();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
